// File: rtl/spi_cmd_regfile_if.sv
// Byte-stream link between the SPI slave driver and spi_cmd_regfile.
// The driver is the master: it supplies received bytes and chip select, and it takes the response byte.
interface spi_cmd_regfile_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cs_n;
    logic [7:0] tx_data;

    modport master (output rx_data, output rx_valid, output cs_n, input tx_data);
    modport slave  (input rx_data, input rx_valid, input cs_n, output tx_data);
endinterface

// File: rtl/spi_cmd_regfile.sv
// SPI command decoder with a parameter register file, a feedback snapshot read path and stretched acks.
// Define SPI_CMD_CHKSUM_EN to require a trailing XOR checksum byte on write frames (adds the CHECK state).
module spi_cmd_regfile #(
    parameter int NUM_REGS   = 4,
    parameter int REG_BYTES  = 2,
    parameter int FB_BYTES   = 4,
    parameter int ACK_CYCLES = 4,
    parameter logic [NUM_REGS*REG_BYTES*8-1:0] RESET_VALUES = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    spi_cmd_regfile_if.slave                spi,
    output logic                            start_ack,
    output logic                            stop_ack,
    output logic [NUM_REGS*REG_BYTES*8-1:0] reg_data,
    output logic [NUM_REGS-1:0]             reg_wr_ack,
    input  logic [FB_BYTES*8-1:0]           fb_data,
    input  logic                            fb_load,
    output logic [7:0]                      err_cnt
);
    localparam int REG_W = REG_BYTES * 8;
    localparam int ALL_W = NUM_REGS * REG_W;
    localparam int FB_W  = FB_BYTES * 8;
    localparam int NACK  = NUM_REGS + 2;
    localparam logic [2:0] REG_LAST = 3'(REG_BYTES - 1);
    localparam logic [2:0] FB_LAST  = 3'(FB_BYTES - 1);
    localparam logic [3:0] NREGS_L  = 4'(NUM_REGS);
    localparam logic [3:0] ACK_LAST = 4'(ACK_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PULSE = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
`ifdef SPI_CMD_CHKSUM_EN
    localparam logic [2:0] ST_CHECK = 3'd4;
`endif

    logic [2:0]       state_r, state_nxt_s;
    logic [2:0]       addr_r;
    logic             rd_fb_r;
    logic             pulse_stop_r;
    logic [2:0]       byte_cnt_r;
    logic [REG_W-1:0] shadow_r;
    logic [REG_W-1:0] commit_val_s;
    logic             commit_s;
    logic             err_inc_s;
    logic             abort_s;
    logic             cs_prev_r;
    logic [FB_W-1:0]  fb_snap_r;
    logic [7:0]       tx_data_r, tx_nxt_s;
    logic [7:0]       err_cnt_r;
    logic [ALL_W-1:0] reg_data_r;
    logic [NACK-1:0]  ack_load_s;
    logic [NACK-1:0]  ack_r;
    logic [3:0]       ack_cnt_r [NACK];
    logic [7:0]       cmd_s;
    logic             wr_cmd_s, rd_cmd_s;
    logic [2:0]       rd_last_s;
`ifdef SPI_CMD_CHKSUM_EN
    logic [7:0]       chk_r;
`endif

    // Byte k of a register or of the feedback snapshot; 0xFF past the end.
    function automatic logic [7:0] pick_byte(input logic fb, input logic [2:0] idx, input logic [2:0] k,
                                             input logic [ALL_W-1:0] regs, input logic [FB_W-1:0] snap);
        logic [7:0] res;
        res = 8'hFF;
        if (fb) begin
            for (int b = 0; b < FB_BYTES; b++) begin
                if (k == 3'(b)) res = snap[b*8 +: 8];
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int b = 0; b < REG_BYTES; b++) begin
                    if (idx == 3'(r) && k == 3'(b)) res = regs[(r*REG_BYTES+b)*8 +: 8];
                end
            end
        end
        return res;
    endfunction

    assign cmd_s     = spi.rx_data;
    assign wr_cmd_s  = (cmd_s[7:3] == 5'b10000) && ({1'b0, cmd_s[2:0]} < NREGS_L);
    assign rd_cmd_s  = (cmd_s[7:3] == 5'b11000) && ({1'b0, cmd_s[2:0]} < NREGS_L);
    assign rd_last_s = rd_fb_r ? FB_LAST : REG_LAST;
    // A chip-select release mid-frame aborts it; a pending pulse still fires.
    assign abort_s   = spi.cs_n && !cs_prev_r && (state_r != ST_IDLE);

    // Next-state, response byte, commit and ack-trigger decode.
    always_comb begin
        state_nxt_s  = state_r;
        tx_nxt_s     = 8'hFF;
        commit_s     = 1'b0;
        commit_val_s = shadow_r;
        err_inc_s    = 1'b0;
        ack_load_s   = '0;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
            err_inc_s   = 1'b1;
            if (state_r == ST_PULSE) begin
                ack_load_s[0] = !pulse_stop_r;
                ack_load_s[1] = pulse_stop_r;
            end else begin
                ack_load_s[1:0] = 2'b00;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (spi.rx_valid) begin
                        if (cmd_s == 8'h06 || cmd_s == 8'h04) begin
                            state_nxt_s = ST_PULSE;
                        end else if (wr_cmd_s) begin
                            state_nxt_s = ST_WRITE;
                        end else if (rd_cmd_s) begin
                            state_nxt_s = ST_READ;
                            tx_nxt_s    = pick_byte(1'b0, cmd_s[2:0], 3'd0, reg_data_r, fb_snap_r);
                        end else if (cmd_s == 8'hAB) begin
                            state_nxt_s = ST_READ;
                            tx_nxt_s    = pick_byte(1'b1, 3'd0, 3'd0, reg_data_r, fb_snap_r);
                        end else begin
                            err_inc_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    state_nxt_s   = ST_IDLE;
                    ack_load_s[0] = !pulse_stop_r;
                    ack_load_s[1] = pulse_stop_r;
                end
                ST_WRITE: begin
                    if (spi.rx_valid && byte_cnt_r == REG_LAST) begin
`ifdef SPI_CMD_CHKSUM_EN
                        state_nxt_s = ST_CHECK;
`else
                        state_nxt_s = ST_IDLE;
                        commit_s    = 1'b1;
                        for (int b = 0; b < REG_BYTES; b++) begin
                            if (byte_cnt_r == 3'(b)) commit_val_s[b*8 +: 8] = spi.rx_data;
                        end
`endif
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end
`ifdef SPI_CMD_CHKSUM_EN
                ST_CHECK: begin
                    if (spi.rx_valid) begin
                        state_nxt_s = ST_IDLE;
                        commit_s    = (spi.rx_data == chk_r);
                        err_inc_s   = (spi.rx_data != chk_r);
                    end else begin
                        state_nxt_s = ST_CHECK;
                    end
                end
`endif
                ST_READ: begin
                    if (spi.rx_valid) begin
                        if (byte_cnt_r == rd_last_s) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            tx_nxt_s = pick_byte(rd_fb_r, addr_r, byte_cnt_r + 3'd1, reg_data_r, fb_snap_r);
                        end
                    end else begin
                        tx_nxt_s = tx_data_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            ack_load_s[2+r] = commit_s && (addr_r == 3'(r));
        end
    end

    // FSM state, response byte, chip-select history and saturating error count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tx_data_r <= 8'hFF;
            cs_prev_r <= 1'b1;
            err_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            tx_data_r <= tx_nxt_s;
            cs_prev_r <= spi.cs_n;
            if (err_inc_s && err_cnt_r != 8'hFF) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    // Frame context: command target, byte counter, write shadow and running checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r       <= 3'd0;
            rd_fb_r      <= 1'b0;
            pulse_stop_r <= 1'b0;
            byte_cnt_r   <= 3'd0;
            shadow_r     <= '0;
`ifdef SPI_CMD_CHKSUM_EN
            chk_r        <= 8'd0;
`endif
        end else if (abort_s) begin
            byte_cnt_r <= 3'd0;
            shadow_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (spi.rx_valid) begin
                        addr_r       <= spi.rx_data[2:0];
                        rd_fb_r      <= (spi.rx_data == 8'hAB);
                        pulse_stop_r <= (spi.rx_data == 8'h04);
                        byte_cnt_r   <= 3'd0;
                        shadow_r     <= '0;
`ifdef SPI_CMD_CHKSUM_EN
                        chk_r        <= spi.rx_data;
`endif
                    end
                end
                ST_WRITE: begin
                    if (spi.rx_valid) begin
`ifdef SPI_CMD_CHKSUM_EN
                        chk_r <= chk_r ^ spi.rx_data;
                        for (int b = 0; b < REG_BYTES; b++) begin
                            if (byte_cnt_r == 3'(b)) shadow_r[b*8 +: 8] <= spi.rx_data;
                        end
`else
                        if (byte_cnt_r == REG_LAST) begin
                            shadow_r <= '0;
                        end else begin
                            for (int b = 0; b < REG_BYTES; b++) begin
                                if (byte_cnt_r == 3'(b)) shadow_r[b*8 +: 8] <= spi.rx_data;
                            end
                        end
`endif
                        byte_cnt_r <= (byte_cnt_r == REG_LAST) ? 3'd0 : byte_cnt_r + 3'd1;
                    end
                end
`ifdef SPI_CMD_CHKSUM_EN
                ST_CHECK: begin
                    if (spi.rx_valid) shadow_r <= '0;
                end
`endif
                ST_READ: begin
                    if (spi.rx_valid) begin
                        byte_cnt_r <= (byte_cnt_r == rd_last_s) ? 3'd0 : byte_cnt_r + 3'd1;
                    end
                end
                default: begin
                    byte_cnt_r <= byte_cnt_r;
                end
            endcase
        end
    end

    // Register file: one whole register replaced per commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_data_r <= RESET_VALUES;
        end else if (commit_s) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (addr_r == 3'(r)) reg_data_r[r*REG_W +: REG_W] <= commit_val_s;
            end
        end
    end

    // Feedback snapshot only moves while no frame is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_snap_r <= '0;
        end else if (fb_load && spi.cs_n) begin
            fb_snap_r <= fb_data;
        end
    end

    // Ack stretchers; a retrigger reloads the full width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r <= '0;
            for (int a = 0; a < NACK; a++) ack_cnt_r[a] <= 4'd0;
        end else begin
            for (int a = 0; a < NACK; a++) begin
                if (ack_load_s[a]) begin
                    ack_cnt_r[a] <= ACK_LAST;
                    ack_r[a]     <= 1'b1;
                end else if (ack_cnt_r[a] != 4'd0) begin
                    ack_cnt_r[a] <= ack_cnt_r[a] - 4'd1;
                    ack_r[a]     <= 1'b1;
                end else begin
                    ack_r[a] <= 1'b0;
                end
            end
        end
    end

    assign spi.tx_data = tx_data_r;
    assign start_ack   = ack_r[0];
    assign stop_ack    = ack_r[1];
    assign reg_wr_ack  = ack_r[NACK-1:2];
    assign reg_data    = reg_data_r;
    assign err_cnt     = err_cnt_r;
endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Randomised self-checking bench for spi_cmd_regfile against a frame-level reference model.
module tb_spi_cmd_regfile;
    localparam int NUM_REGS   = 4;
    localparam int REG_BYTES  = 2;
    localparam int FB_BYTES   = 4;
    localparam int ACK_CYCLES = 4;
    localparam logic [63:0] RESET_VALUES = 64'hA4A4_A3A3_A2A2_A1A1;

    logic        clk;
    logic        rst;
    logic        start_ack, stop_ack;
    logic [63:0] reg_data;
    logic [3:0]  reg_wr_ack;
    logic [31:0] fb_data;
    logic        fb_load;
    logic [7:0]  err_cnt;

    spi_cmd_regfile_if spi();

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_regs [NUM_REGS];
    logic [31:0] m_snap;
    int          m_err;
    logic [7:0]  rd_obs [5];

    spi_cmd_regfile #(
        .NUM_REGS(NUM_REGS), .REG_BYTES(REG_BYTES), .FB_BYTES(FB_BYTES),
        .ACK_CYCLES(ACK_CYCLES), .RESET_VALUES(RESET_VALUES)
    ) dut (
        .clk(clk), .rst(rst), .spi(spi), .start_ack(start_ack), .stop_ack(stop_ack),
        .reg_data(reg_data), .reg_wr_ack(reg_wr_ack), .fb_data(fb_data), .fb_load(fb_load),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model_image();
        logic [63:0] img;
        for (int r = 0; r < NUM_REGS; r++) img[r*16 +: 16] = m_regs[r];
        return img;
    endfunction

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    // Called at a negedge; holds the strobe for one cycle and returns at the next negedge.
    task automatic send_byte(input logic [7:0] b);
        spi.rx_data  = b;
        spi.rx_valid = 1'b1;
        @(negedge clk);
        spi.rx_valid = 1'b0;
    endtask

    task automatic write_frame(input int idx, input logic [15:0] val);
        logic [7:0] cmd, chk;
        cmd = 8'h80 | 8'(idx);
        chk = cmd;
        send_byte(cmd);
        for (int b = 0; b < REG_BYTES; b++) begin
            send_byte(val[b*8 +: 8]);
            chk = chk ^ val[b*8 +: 8];
        end
`ifdef SPI_CMD_CHKSUM_EN
        send_byte(chk);
`endif
        m_regs[idx] = val;
    endtask

    task automatic read_frame(input logic [7:0] cmd, input int n);
        send_byte(cmd);
        rd_obs[0] = spi.tx_data;
        for (int k = 1; k <= n; k++) begin
            send_byte(8'($urandom));
            rd_obs[k] = spi.tx_data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; spi.cs_n = 1'b1; spi.rx_valid = 1'b0; spi.rx_data = 8'h00;
        fb_load = 1'b0; fb_data = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (reg_data !== RESET_VALUES) begin errors++; $display("FAIL reset_regs: got %h expected %h", reg_data, RESET_VALUES); end
        checks++; if (spi.tx_data !== 8'hFF) begin errors++; $display("FAIL reset_tx: got %h expected ff", spi.tx_data); end
        checks++; if ({start_ack, stop_ack, reg_wr_ack} !== 6'b0) begin errors++; $display("FAIL reset_acks: got %b expected 0", {start_ack, stop_ack, reg_wr_ack}); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        rst = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) m_regs[r] = RESET_VALUES[r*16 +: 16];
        m_snap = 32'h0; m_err = 0;
        @(negedge clk); spi.cs_n = 1'b0; @(negedge clk);
        read_frame(8'hAB, 4);
        for (int k = 0; k < 5; k++) begin
            logic [7:0] e;
            e = (k < 4) ? m_snap[k*8 +: 8] : 8'hFF;
            checks++; if (rd_obs[k] !== e) begin errors++; $display("FAIL reset_snap[%0d]: got %h expected %h", k, rd_obs[k], e); end
        end
    endtask

    task automatic test_write();
        logic [7:0] hist1, oth;
        send_byte(8'h81); send_byte(8'h34);
        checks++; if (reg_data !== model_image()) begin errors++; $display("FAIL write_early: got %h expected %h", reg_data, model_image()); end
        send_byte(8'h12);
`ifdef SPI_CMD_CHKSUM_EN
        send_byte(8'h81 ^ 8'h34 ^ 8'h12);
`endif
        m_regs[1] = 16'h1234;
        checks++; if (reg_data !== model_image()) begin errors++; $display("FAIL write_commit: got %h expected %h", reg_data, model_image()); end
        hist1 = 8'h0; oth = 8'h0;
        for (int s = 0; s < 8; s++) begin
            hist1[s] = reg_wr_ack[1];
            oth[s]   = |(reg_wr_ack & 4'b1101);
            @(negedge clk);
        end
        checks++; if (hist1 !== 8'h0F) begin errors++; $display("FAIL write_ack_width: got %b expected 00001111", hist1); end
        checks++; if (oth !== 8'h00) begin errors++; $display("FAIL write_ack_other: got %b expected 0", oth); end
    endtask

    task automatic test_feedback();
        spi.cs_n = 1'b1; fb_data = 32'hDEADBEEF; fb_load = 1'b1;
        @(negedge clk);
        m_snap = 32'hDEADBEEF;
        spi.cs_n = 1'b0; fb_data = $urandom; fb_load = 1'b1;
        @(negedge clk);
        read_frame(8'hAB, 4);
        fb_load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] e;
            e = (k < 4) ? m_snap[k*8 +: 8] : 8'hFF;
            checks++; if (rd_obs[k] !== e) begin errors++; $display("FAIL fb_byte[%0d]: got %h expected %h", k, rd_obs[k], e); end
        end
    endtask

    task automatic test_cs_abort();
        logic       any_ack;
        logic [7:0] hist;
        logic [15:0] v;
        send_byte(8'h80); send_byte(8'h55);
        spi.cs_n = 1'b1; bump_err();
        any_ack = 1'b0;
        repeat (6) begin @(negedge clk); any_ack |= |reg_wr_ack; end
        checks++; if (any_ack !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", any_ack); end
        checks++; if (reg_data !== model_image()) begin errors++; $display("FAIL abort_regs: got %h expected %h", reg_data, model_image()); end
        checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL abort_err: got %0d expected %0d", err_cnt, m_err); end
        checks++; if (spi.tx_data !== 8'hFF) begin errors++; $display("FAIL abort_tx: got %h expected ff", spi.tx_data); end
        spi.cs_n = 1'b0; @(negedge clk);
        v = 16'($urandom);
        write_frame(0, v);
        checks++; if (reg_data !== model_image()) begin errors++; $display("FAIL abort_then_write: got %h expected %h", reg_data, model_image()); end
        send_byte(8'hC1);
        spi.cs_n = 1'b1; bump_err();
        repeat (2) @(negedge clk);
        checks++; if (spi.tx_data !== 8'hFF) begin errors++; $display("FAIL abort_read_tx: got %h expected ff", spi.tx_data); end
        checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL abort_read_err: got %0d expected %0d", err_cnt, m_err); end
        spi.cs_n = 1'b0; @(negedge clk);
        send_byte(8'h06);
        spi.cs_n = 1'b1; bump_err();
        hist = 8'h0;
        for (int s = 0; s < 8; s++) begin hist[s] = start_ack; @(negedge clk); end
        checks++; if (hist !== 8'h1E) begin errors++; $display("FAIL abort_pulse: got %b expected 00011110", hist); end
        checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL abort_pulse_err: got %0d expected %0d", err_cnt, m_err); end
        spi.cs_n = 1'b0; @(negedge clk);
    endtask

    task automatic test_start_stop();
        int st_t[$];
        int sp_t[$];
        int last;
        logic es, ep;
        logic [7:0] c;
        last = -10;
        for (int t = 0; t < 64; t++) begin
            es = 1'b0; ep = 1'b0;
            foreach (st_t[j]) if (t >= st_t[j] + 2 && t <= st_t[j] + 1 + ACK_CYCLES) es = 1'b1;
            foreach (sp_t[j]) if (t >= sp_t[j] + 2 && t <= sp_t[j] + 1 + ACK_CYCLES) ep = 1'b1;
            checks++; if (start_ack !== es) begin errors++; $display("FAIL start_ack t=%0d: got %b expected %b", t, start_ack, es); end
            checks++; if (stop_ack !== ep) begin errors++; $display("FAIL stop_ack t=%0d: got %b expected %b", t, stop_ack, ep); end
            if (t == 0 || (t >= 8 && t >= last + 2 && $urandom_range(2) == 0)) begin
                c = (t == 0 || $urandom_range(1) == 0) ? 8'h06 : 8'h04;
                spi.rx_data = c; spi.rx_valid = 1'b1;
                if (c == 8'h06) st_t.push_back(t); else sp_t.push_back(t);
                last = t;
            end else begin
                spi.rx_valid = 1'b0;
            end
            @(negedge clk);
        end
        spi.rx_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        int idx, j;
        logic [15:0] v;
        repeat (12) begin
            idx = $urandom_range(NUM_REGS - 1);
            v = 16'($urandom);
            write_frame(idx, v);
            repeat ($urandom_range(2)) @(negedge clk);
            checks++; if (reg_data !== model_image()) begin errors++; $display("FAIL rand_regs: got %h expected %h", reg_data, model_image()); end
            j = $urandom_range(NUM_REGS - 1);
            read_frame(8'hC0 | 8'(j), 2);
            for (int k = 0; k < 3; k++) begin
                logic [7:0] e;
                e = (k < 2) ? m_regs[j][k*8 +: 8] : 8'hFF;
                checks++; if (rd_obs[k] !== e) begin errors++; $display("FAIL rand_read r%0d[%0d]: got %h expected %h", j, k, rd_obs[k], e); end
            end
            if ($urandom_range(2) == 0) begin
                spi.cs_n = 1'b1; fb_data = $urandom; fb_load = 1'b1;
                @(negedge clk);
                m_snap = fb_data; fb_load = 1'b0; spi.cs_n = 1'b0;
                @(negedge clk);
                read_frame(8'hAB, 4);
                for (int k = 0; k < 5; k++) begin
                    logic [7:0] e;
                    e = (k < 4) ? m_snap[k*8 +: 8] : 8'hFF;
                    checks++; if (rd_obs[k] !== e) begin errors++; $display("FAIL rand_fb[%0d]: got %h expected %h", k, rd_obs[k], e); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        write_frame(3, 16'($urandom));
        write_frame(2, 16'($urandom));
        read_frame(8'hC3, 2);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] e;
            e = (k < 2) ? m_regs[3][k*8 +: 8] : 8'hFF;
            checks++; if (rd_obs[k] !== e) begin errors++; $display("FAIL b2b_read[%0d]: got %h expected %h", k, rd_obs[k], e); end
        end
        checks++; if (reg_data !== model_image()) begin errors++; $display("FAIL b2b_regs: got %h expected %h", reg_data, model_image()); end
    endtask

`ifdef SPI_CMD_CHKSUM_EN
    task automatic test_checksum();
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h02); send_byte(8'h83);
        m_regs[0] = 16'h0201;
        checks++; if (reg_data !== model_image()) begin errors++; $display("FAIL chk_good: got %h expected %h", reg_data, model_image()); end
        send_byte(8'h80); send_byte(8'h05); send_byte(8'h06); send_byte(8'h00);
        bump_err();
        @(negedge clk);
        checks++; if (reg_data !== model_image()) begin errors++; $display("FAIL chk_bad_regs: got %h expected %h", reg_data, model_image()); end
        checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL chk_bad_err: got %0d expected %0d", err_cnt, m_err); end
    endtask
`endif

    task automatic test_errors();
        logic [7:0] bad [7] = '{8'h77, 8'h00, 8'hFF, 8'h84, 8'hC4, 8'h88, 8'h05};
        send_byte(8'h77); bump_err();
        checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL err_unknown: got %0d expected %0d", err_cnt, m_err); end
        send_byte(8'hC4); bump_err();
        checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL err_bad_idx: got %0d expected %0d", err_cnt, m_err); end
        checks++; if (spi.tx_data !== 8'hFF) begin errors++; $display("FAIL err_bad_idx_tx: got %h expected ff", spi.tx_data); end
        read_frame(8'hC2, 2);
        checks++; if (rd_obs[0] !== m_regs[2][7:0]) begin errors++; $display("FAIL err_then_read: got %h expected %h", rd_obs[0], m_regs[2][7:0]); end
        for (int n = 0; n < 300; n++) begin
            send_byte(bad[$urandom_range(6)]);
            bump_err();
            if (n == 99) begin
                checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL err_mid: got %0d expected %0d", err_cnt, m_err); end
            end
        end
        checks++; if (err_cnt !== 8'(m_err)) begin errors++; $display("FAIL err_sat_model: got %0d expected %0d", err_cnt, m_err); end
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL err_sat: got %0d expected 255", err_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_write();
        test_feedback();
        test_cs_abort();
        test_start_stop();
        test_random();
        test_back_to_back();
`ifdef SPI_CMD_CHKSUM_EN
        test_checksum();
`endif
        test_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
